xbus_arbiter: RTL and testbench

XBUS_ARBITER -- requirements
Module: xbus_arbiter

---
 rtl/xbus_arbiter_pkg.sv | 14 +
 rtl/xbus_arb_pick.sv | 24 ++
 rtl/xbus_arbiter.sv | 112 +++++++++++
 tb/tb_xbus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_arbiter_pkg.sv
// Shared widths and request bundle for the two-master xbus arbiter.
// Widths mirror the xdefs.vh bus definitions used by the rest of the system.
package xbus_arbiter_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
   } xbus_req_t;

endpackage

// File: rtl/xbus_arb_pick.sv
// Combinational winner selection between master 0 and master 1.
// Build option: XBUS_ARB_RR_EN selects round-robin on ties, otherwise master 0 wins.
module xbus_arb_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

`ifdef XBUS_ARB_RR_EN
   // Tie goes to the master that was not granted last time.
   always_comb begin
      winner = ~req[0];
      if (&req) winner = ~last;
   end
`else
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      winner = ~req[0];
   end
`endif

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master bus arbiter: IDLE -> ACCESS (one-cycle bus_sel) -> RESP (ack pulse).
// Build option: XBUS_ARB_RR_EN enables round-robin tie breaking in xbus_arb_pick.
module xbus_arbiter
   import xbus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_we,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   state_t                      state_q, state_d;
   xbus_req_t                   bus_q, bus_d;
   logic                        owner_q, owner_d;
   logic                        last_q, last_d;
   logic [1:0]                  ack_q, ack_d;
   logic [1:0][DATA_W-1:0]      rdata_q, rdata_d;
   logic [1:0]                  req;
   xbus_req_t [1:0]             mreq;
   logic                        winner;

   assign req     = {m1_req, m0_req};
   assign mreq[M0] = '{addr: m0_addr, we: m0_we, wdata: m0_wdata};
   assign mreq[M1] = '{addr: m1_addr, we: m1_we, wdata: m1_wdata};

   xbus_arb_pick u_pick (
      .req    (req),
      .last   (last_q),
      .winner (winner)
   );

   // Read data is captured at the end of ACCESS so it is registered and valid alongside ack in RESP.
   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      owner_d = owner_q;
      last_d  = last_q;
      ack_d   = '0;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               bus_d   = mreq[winner];
               owner_d = winner;
               last_d  = winner;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            rdata_d[owner_q] = bus_rdata;
            ack_d[owner_q]   = 1'b1;
            state_d          = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         bus_q   <= '0;
         owner_q <= M0;
         last_q  <= M1;
         ack_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus_sel   = (state_q == ACCESS);
   assign bus_addr  = bus_q.addr;
   assign bus_we    = bus_q.we;
   assign bus_wdata = bus_q.wdata;
   assign bus_owner = owner_q;
   assign m0_ack    = ack_q[M0];
   assign m1_ack    = ack_q[M1];
   assign m0_rdata  = rdata_q[M0];
   assign m1_rdata  = rdata_q[M1];

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter; inputs change and outputs are checked on the falling edge.
// Round-robin expectations apply when XBUS_ARB_RR_EN is defined for the build.
module tb_xbus_arbiter;
   import xbus_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m0_we, m0_ack;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic              m1_req, m1_we, m1_ack;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;
   logic              bus_sel, bus_we, bus_owner;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata, bus_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   xbus_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_we     (m0_we),
      .m0_wdata  (m0_wdata),
      .m0_ack    (m0_ack),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_we     (m1_we),
      .m1_wdata  (m1_wdata),
      .m1_ack    (m1_ack),
      .m1_rdata  (m1_rdata),
      .bus_sel   (bus_sel),
      .bus_addr  (bus_addr),
      .bus_we    (bus_we),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_owner (bus_owner)
   );

   task automatic do_reset();
      rst    = 1'b0;
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst    = 1'b0;
      m0_req = 1'b1;
      m1_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({bus_sel, m0_ack, m1_ack, bus_we, bus_owner} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got sel/ack0/ack1/we/owner=%b expected 00000",
                  {bus_sel, m0_ack, m1_ack, bus_we, bus_owner});
      end
      n_chk++;
      if ({bus_addr, bus_wdata, m0_rdata, m1_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h wdata=%h r0=%h r1=%h expected all zero",
                  bus_addr, bus_wdata, m0_rdata, m1_rdata);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      rst    = 1'b1;
   endtask

   task automatic test_single_read();
      m0_req    = 1'b1;
      m0_addr   = 16'h0010;
      m0_we     = 1'b0;
      bus_rdata = 32'hDEADBEEF;
      @(negedge clk);
      n_chk++;
      if ({bus_sel, bus_we, bus_owner, m0_ack} !== 4'b1000 || bus_addr !== 16'h0010) begin
         n_fail++;
         $display("FAIL read_access: got sel/we/owner/ack=%b addr=%h expected 1000 addr=0010",
                  {bus_sel, bus_we, bus_owner, m0_ack}, bus_addr);
      end
      @(negedge clk);
      n_chk++;
      if ({m0_ack, m1_ack, bus_sel} !== 3'b100 || m0_rdata !== 32'hDEADBEEF || m1_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL read_resp: got ack0/ack1/sel=%b r0=%h r1=%h expected 100 r0=deadbeef r1=0",
                  {m0_ack, m1_ack, bus_sel}, m0_rdata, m1_rdata);
      end
      m0_req    = 1'b0;
      bus_rdata = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({m0_ack, bus_sel} !== 2'b00 || m0_rdata !== 32'hDEADBEEF || bus_addr !== 16'h0010) begin
         n_fail++;
         $display("FAIL read_hold: got ack/sel=%b r0=%h addr=%h expected 00 r0=deadbeef addr=0010",
                  {m0_ack, bus_sel}, m0_rdata, bus_addr);
      end
   endtask

   task automatic test_priority();
      do_reset();
      m0_req    = 1'b1;
      m0_addr   = 16'h0030;
      m0_we     = 1'b0;
      m1_req    = 1'b1;
      m1_addr   = 16'h0040;
      m1_we     = 1'b0;
      bus_rdata = 32'h11111111;
      @(negedge clk);
      n_chk++;
      if ({bus_sel, bus_owner} !== 2'b10 || bus_addr !== 16'h0030) begin
         n_fail++;
         $display("FAIL prio_first: got sel/owner=%b addr=%h expected 10 addr=0030",
                  {bus_sel, bus_owner}, bus_addr);
      end
      @(negedge clk);
      n_chk++;
      if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h11111111) begin
         n_fail++;
         $display("FAIL prio_ack0: got ack0/ack1=%b r0=%h expected 10 r0=11111111",
                  {m0_ack, m1_ack}, m0_rdata);
      end
      m0_req    = 1'b0;
      bus_rdata = 32'h22222222;
      @(negedge clk);
      n_chk++;
      if ({m0_ack, m1_ack, bus_sel} !== 3'b000) begin
         n_fail++;
         $display("FAIL prio_idle: got ack0/ack1/sel=%b expected 000", {m0_ack, m1_ack, bus_sel});
      end
      @(negedge clk);
      n_chk++;
      if ({bus_sel, bus_owner} !== 2'b11 || bus_addr !== 16'h0040) begin
         n_fail++;
         $display("FAIL prio_second: got sel/owner=%b addr=%h expected 11 addr=0040",
                  {bus_sel, bus_owner}, bus_addr);
      end
      @(negedge clk);
      n_chk++;
      if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'h22222222 || m0_rdata !== 32'h11111111) begin
         n_fail++;
         $display("FAIL prio_ack1: got ack0/ack1=%b r0=%h r1=%h expected 01 r0=11111111 r1=22222222",
                  {m0_ack, m1_ack}, m0_rdata, m1_rdata);
      end
      m1_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] exp_r0, exp_r1, rd;
      logic              e;
      do_reset();
      exp_r0  = '0;
      exp_r1  = '0;
      m0_req  = 1'b1;
      m0_addr = 16'h0100;
      m0_we   = 1'b0;
      m1_req  = 1'b1;
      m1_addr = 16'h0200;
      m1_we   = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef XBUS_ARB_RR_EN
         e = k[0];
`else
         e = 1'b0;
`endif
         rd        = 32'hC0000000 + DATA_W'(k);
         bus_rdata = rd;
         @(negedge clk);
         n_chk++;
         if ({bus_sel, bus_owner} !== {1'b1, e} || bus_addr !== (e ? 16'h0200 : 16'h0100)) begin
            n_fail++;
            $display("FAIL b2b_access[%0d]: got sel/owner=%b addr=%h expected owner=%b",
                     k, {bus_sel, bus_owner}, bus_addr, e);
         end
         if (e) exp_r1 = rd;
         else   exp_r0 = rd;
         @(negedge clk);
         n_chk++;
         if ({m1_ack, m0_ack} !== (e ? 2'b10 : 2'b01) || m0_rdata !== exp_r0 || m1_rdata !== exp_r1) begin
            n_fail++;
            $display("FAIL b2b_ack[%0d]: got ack1/ack0=%b r0=%h r1=%h expected owner=%b r0=%h r1=%h",
                     k, {m1_ack, m0_ack}, m0_rdata, m1_rdata, e, exp_r0, exp_r1);
         end
         @(negedge clk);
         n_chk++;
         if ({m0_ack, m1_ack, bus_sel} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_idle[%0d]: got ack0/ack1/sel=%b expected 000", k, {m0_ack, m1_ack, bus_sel});
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_drop();
      m0_req    = 1'b0;
      m1_req    = 1'b1;
      m1_we     = 1'b1;
      m1_addr   = 16'h0020;
      m1_wdata  = 32'h00000055;
      bus_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      n_chk++;
      if ({bus_sel, bus_we, bus_owner} !== 3'b111 || bus_addr !== 16'h0020 || bus_wdata !== 32'h55) begin
         n_fail++;
         $display("FAIL write_access: got sel/we/owner=%b addr=%h wdata=%h expected 111 addr=0020 wdata=55",
                  {bus_sel, bus_we, bus_owner}, bus_addr, bus_wdata);
      end
      m1_req = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({m1_ack, m0_ack, bus_owner, bus_sel} !== 4'b1010) begin
         n_fail++;
         $display("FAIL write_ack: got ack1/ack0/owner/sel=%b expected 1010",
                  {m1_ack, m0_ack, bus_owner, bus_sel});
      end
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({m1_ack, bus_sel} !== 2'b00 || bus_wdata !== 32'h55 || bus_we !== 1'b1) begin
         n_fail++;
         $display("FAIL write_after: got ack1/sel=%b we=%b wdata=%h expected 00 we=1 wdata=55",
                  {m1_ack, bus_sel}, bus_we, bus_wdata);
      end
   endtask

   task automatic test_reset_mid();
      m0_req    = 1'b1;
      m0_addr   = 16'h0044;
      m0_we     = 1'b0;
      bus_rdata = 32'h0BADF00D;
      @(negedge clk);
      n_chk++;
      if (bus_sel !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_access: got sel=%b expected 1", bus_sel);
      end
      rst    = 1'b0;
      m0_req = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({bus_sel, m0_ack, m1_ack, bus_we, bus_owner} !== 5'b0 ||
          {bus_addr, bus_wdata, m0_rdata, m1_rdata} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_state: got sel/ack0/ack1/we/owner=%b addr=%h wdata=%h r0=%h r1=%h expected all zero",
                  {bus_sel, m0_ack, m1_ack, bus_we, bus_owner}, bus_addr, bus_wdata, m0_rdata, m1_rdata);
      end
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({bus_sel, m0_ack, m1_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_noack: got sel/ack0/ack1=%b expected 000", {bus_sel, m0_ack, m1_ack});
      end
   endtask

   initial begin
      rst       = 1'b0;
      m0_req    = 1'b0;
      m0_addr   = '0;
      m0_we     = 1'b0;
      m0_wdata  = '0;
      m1_req    = 1'b0;
      m1_addr   = '0;
      m1_we     = 1'b0;
      m1_wdata  = '0;
      bus_rdata = '0;
      test_reset();
      test_single_read();
      test_priority();
      test_back_to_back();
      test_write_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
